decode_issue_ctrl: RTL and testbench

- Sequences the combinational instruction decoder.
- Holds one fetched instruction in an instruction register (IR) and presents it to the decoder.
- Issues the instruction to the execute stage with a valid/ready handshake.
- Stalls on hazards:
  - RAW/WAW hazards against outstanding load-queue writebacks, tracked in a 32-entry scoreboard.
  - Serialises CSR accesses and fences.
  - Parks after an illegal instruction until the pipeline is redirected.

---
 rtl/decode_issue_ctrl.sv | 158 +++++++++++++++
 tb/tb_decode_issue_ctrl.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/decode_issue_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | decode_issue_ctrl: IR holding, hazard scoreboard and issue handshake.    |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module decode_issue_ctrl #(
  parameter int P_XLEN    = 32,
  parameter int P_ZONE_SZ = 2
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic                 ifq_valid_i,
  input  logic [31:0]          ifq_ins_i,
  input  logic [P_XLEN-1:0]    ifq_pc_i,
  output logic                 ifq_ready_o,
  output logic [31:0]          dec_ins_o,
  input  logic                 dec_ins_err_i,
  input  logic [P_ZONE_SZ-1:0] dec_zone_i,
  input  logic                 dec_csr_access_i,
  output logic                 exs_valid_o,
  input  logic                 exs_ready_i,
  output logic [31:0]          exs_ins_o,
  output logic [P_XLEN-1:0]    exs_pc_o,
  output logic                 exs_ins_err_o,
  input  logic                 csr_done_i,
  input  logic                 ldq_wb_valid_i,
  input  logic [4:0]           ldq_wb_addr_i,
  input  logic                 flush_i,
  output logic                 hazard_o
);

  localparam logic [P_ZONE_SZ-1:0] C_ZONE_LOADQ = P_ZONE_SZ'(2);

  localparam logic [6:0] C_OP_LUI    = 7'b0110111;
  localparam logic [6:0] C_OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] C_OP_JAL    = 7'b1101111;
  localparam logic [6:0] C_OP_JALR   = 7'b1100111;
  localparam logic [6:0] C_OP_BRANCH = 7'b1100011;
  localparam logic [6:0] C_OP_LOAD   = 7'b0000011;
  localparam logic [6:0] C_OP_STORE  = 7'b0100011;
  localparam logic [6:0] C_OP_OPIMM  = 7'b0010011;
  localparam logic [6:0] C_OP_OP     = 7'b0110011;
  localparam logic [6:0] C_OP_SYSTEM = 7'b1110011;
  localparam logic [6:0] C_OP_FENCE  = 7'b0001111;

  typedef enum logic [1:0] {
    ST_RUN       = 2'd0,
    ST_CSR_WAIT  = 2'd1,
    ST_TRAP_WAIT = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic                ir_valid_q, ir_valid_d;
  logic [31:0]         ir_q, ir_d;
  logic [P_XLEN-1:0]   pc_q, pc_d;
  logic [31:0]         sb_q, sb_d;

  logic [6:0] w_opcode;
  logic [2:0] w_funct3;
  logic [4:0] w_rs1, w_rs2, w_rd;
  logic       w_uses_rs1, w_uses_rs2, w_writes_rd;
  logic       w_hit, w_serial, w_blk, w_fire, w_accept;

  assign w_opcode = ir_q[6:0];
  assign w_funct3 = ir_q[14:12];
  assign w_rd     = ir_q[11:7];
  assign w_rs1    = ir_q[19:15];
  assign w_rs2    = ir_q[24:20];

  always_comb begin
    w_uses_rs1  = !((w_opcode == C_OP_LUI) || (w_opcode == C_OP_AUIPC) ||
                    (w_opcode == C_OP_JAL) ||
                    ((w_opcode == C_OP_SYSTEM) && w_funct3[2]));
    w_uses_rs2  = (w_opcode == C_OP_BRANCH) || (w_opcode == C_OP_STORE) ||
                  (w_opcode == C_OP_OP);
    w_writes_rd = (w_opcode == C_OP_LUI) || (w_opcode == C_OP_AUIPC) ||
                  (w_opcode == C_OP_JAL) || (w_opcode == C_OP_JALR) ||
                  (w_opcode == C_OP_LOAD) || (w_opcode == C_OP_OPIMM) ||
                  (w_opcode == C_OP_OP) ||
                  ((w_opcode == C_OP_SYSTEM) && (w_funct3 != 3'd0));
  end

  // Registered scoreboard only: a writeback unblocks the following cycle.
  always_comb begin
    w_hit    = (w_uses_rs1  && (w_rs1 != 5'd0) && sb_q[w_rs1]) ||
               (w_uses_rs2  && (w_rs2 != 5'd0) && sb_q[w_rs2]) ||
               (w_writes_rd && (w_rd  != 5'd0) && sb_q[w_rd]);
    w_serial = (dec_csr_access_i || (w_opcode == C_OP_FENCE)) && (sb_q != 32'd0);
    w_blk    = w_hit || w_serial || (state_q != ST_RUN);
  end

  assign exs_valid_o   = !reset_i && ir_valid_q && !w_blk && !flush_i;
  assign w_fire        = exs_valid_o && exs_ready_i;
  assign ifq_ready_o   = !reset_i && !flush_i && (!ir_valid_q || w_fire);
  assign hazard_o      = !reset_i && ir_valid_q && w_blk;
  assign w_accept      = ifq_valid_i && ifq_ready_o;
  assign dec_ins_o     = ir_q;
  assign exs_ins_o     = ir_q;
  assign exs_pc_o      = pc_q;
  assign exs_ins_err_o = dec_ins_err_i;

  always_comb begin
    ir_valid_d = ir_valid_q;
    ir_d       = ir_q;
    pc_d       = pc_q;
    if (flush_i) begin
      ir_valid_d = 1'b0;
    end else if (w_accept) begin
      ir_valid_d = 1'b1;
      ir_d       = ifq_ins_i;
      pc_d       = ifq_pc_i;
    end else if (w_fire) begin
      ir_valid_d = 1'b0;
    end
  end

  always_comb begin
    state_d = state_q;
    if (flush_i) begin
      state_d = ST_RUN;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (w_fire && dec_ins_err_i)         state_d = ST_TRAP_WAIT;
          else if (w_fire && dec_csr_access_i) state_d = ST_CSR_WAIT;
        end
        ST_CSR_WAIT:  if (csr_done_i) state_d = ST_RUN;
        ST_TRAP_WAIT: state_d = ST_TRAP_WAIT;
        default:      state_d = ST_RUN;
      endcase
    end
  end

  // Clear applied before set so a same-register collision leaves the bit set.
  always_comb begin
    sb_d = sb_q;
    if (ldq_wb_valid_i) sb_d[ldq_wb_addr_i] = 1'b0;
    if (w_fire && (dec_zone_i == C_ZONE_LOADQ) && (w_rd != 5'd0)) sb_d[w_rd] = 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q    <= ST_RUN;
      ir_valid_q <= 1'b0;
      ir_q       <= 32'd0;
      pc_q       <= '0;
      sb_q       <= 32'd0;
    end else begin
      state_q    <= state_d;
      ir_valid_q <= ir_valid_d;
      ir_q       <= ir_d;
      pc_q       <= pc_d;
      sb_q       <= sb_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_decode_issue_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_decode_issue_ctrl: randomized bench with reference model, scoreboard. |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_decode_issue_ctrl;

  localparam int N_CYCLES = 4000;

  logic        clk_i = 1'b0;
  logic        reset_i = 1'b1;
  logic        ifq_valid_i = 1'b0;
  logic [31:0] ifq_ins_i = 32'd0;
  logic [31:0] ifq_pc_i = 32'd0;
  logic        ifq_ready_o;
  logic [31:0] dec_ins_o;
  logic        dec_ins_err_i;
  logic [1:0]  dec_zone_i;
  logic        dec_csr_access_i;
  logic        exs_valid_o;
  logic        exs_ready_i = 1'b0;
  logic [31:0] exs_ins_o;
  logic [31:0] exs_pc_o;
  logic        exs_ins_err_o;
  logic        csr_done_i = 1'b0;
  logic        ldq_wb_valid_i = 1'b0;
  logic [4:0]  ldq_wb_addr_i = 5'd0;
  logic        flush_i = 1'b0;
  logic        hazard_o;

  int checks = 0;
  int errors = 0;
  logic [64:0] exp_q[$];

  decode_issue_ctrl #(.P_XLEN(32), .P_ZONE_SZ(2)) dut (
    .clk_i(clk_i), .reset_i(reset_i),
    .ifq_valid_i(ifq_valid_i), .ifq_ins_i(ifq_ins_i), .ifq_pc_i(ifq_pc_i),
    .ifq_ready_o(ifq_ready_o), .dec_ins_o(dec_ins_o),
    .dec_ins_err_i(dec_ins_err_i), .dec_zone_i(dec_zone_i),
    .dec_csr_access_i(dec_csr_access_i),
    .exs_valid_o(exs_valid_o), .exs_ready_i(exs_ready_i),
    .exs_ins_o(exs_ins_o), .exs_pc_o(exs_pc_o), .exs_ins_err_o(exs_ins_err_o),
    .csr_done_i(csr_done_i), .ldq_wb_valid_i(ldq_wb_valid_i),
    .ldq_wb_addr_i(ldq_wb_addr_i), .flush_i(flush_i), .hazard_o(hazard_o)
  );

  always #5 clk_i = ~clk_i;

  // Instruction classification from RV32I opcode tables.
  function automatic logic is_legal(input logic [31:0] ins);
    case (ins[6:0])
      7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111, 7'b1100011, 7'b0000011,
      7'b0100011, 7'b0010011, 7'b0110011, 7'b1110011, 7'b0001111: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic is_csr(input logic [31:0] ins);
    return (ins[6:0] == 7'b1110011) && (ins[14:12] != 3'd0);
  endfunction

  function automatic logic is_load(input logic [31:0] ins);
    return ins[6:0] == 7'b0000011;
  endfunction

  // Set of architectural registers the instruction touches for hazard purposes.
  function automatic logic [31:0] touched_regs(input logic [31:0] ins);
    logic [31:0] m;
    logic [6:0]  op;
    op = ins[6:0];
    m = 32'd0;
    if (!(op inside {7'b0110111, 7'b0010111, 7'b1101111}) &&
        !(op == 7'b1110011 && ins[14]))
      m[ins[19:15]] = 1'b1;
    if (op inside {7'b1100011, 7'b0100011, 7'b0110011})
      m[ins[24:20]] = 1'b1;
    if ((op inside {7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111, 7'b0000011,
                    7'b0010011, 7'b0110011}) || is_csr(ins))
      m[ins[11:7]] = 1'b1;
    m[0] = 1'b0;
    return m;
  endfunction

  // Bench plays the combinational decoder.
  always_comb begin
    dec_ins_err_i    = !is_legal(dec_ins_o);
    dec_csr_access_i = is_csr(dec_ins_o);
    dec_zone_i       = is_load(dec_ins_o) ? 2'd2 : 2'd1;
  end

  function automatic logic [31:0] rand_ins();
    logic [4:0] a, b, d;
    a = 5'($urandom_range(0, 7));
    b = 5'($urandom_range(0, 7));
    d = 5'($urandom_range(0, 7));
    case ($urandom_range(0, 13))
      0, 1:    return {12'($urandom), a, 3'b000, d, 7'b0010011};
      2:       return {7'd0, b, a, 3'b000, d, 7'b0110011};
      3, 4, 5: return {12'($urandom), a, 3'b010, d, 7'b0000011};
      6:       return {7'd0, b, a, 3'b010, 5'd0, 7'b0100011};
      7:       return {7'd0, b, a, 3'b000, 5'd0, 7'b1100011};
      8:       return {20'($urandom), d, 7'b0110111};
      9:       return {20'd0, d, 7'b1101111};
      10:      return {12'h300, a, 3'b001, d, 7'b1110011};
      11:      return {12'h300, a, 3'b101, d, 7'b1110011};
      12:      return ($urandom_range(0, 1) == 0) ? 32'h0ff0000f : 32'h00000073;
      default: return 32'hffffffff;
    endcase
  endfunction

  // Monitor: every DUT issue must match the oldest predicted issue.
  initial begin
    logic [64:0] e, a;
    forever begin
      @(negedge clk_i);
      #1;
      if (exs_valid_o && exs_ready_i) begin
        a = {exs_ins_err_o, exs_ins_o, exs_pc_o};
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_issue: got %h, none expected at %0t", a, $time);
        end else begin
          e = exp_q.pop_front();
          if (a !== e) begin
            errors++;
            $display("FAIL issue_payload: got %h, expected %h at %0t", a, e, $time);
          end
        end
      end
    end
  end

  task automatic chk(input string name, input logic got, input logic exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %b, expected %b at %0t", name, got, exp, $time);
    end
  endtask

  // Reference model: instruction slot, pending-load set and a wait mode.
  logic        m_irv;
  logic [31:0] m_ir, m_pc;
  logic [31:0] m_pend;
  int          m_mode;  // 0 running, 1 awaiting CSR completion, 2 parked after illegal

  initial begin
    logic blocked, e_valid, e_ready, e_haz, fire;
    m_irv = 0; m_ir = 0; m_pc = 0; m_pend = 0; m_mode = 0;
    reset_i = 1'b1;
    repeat (3) begin
      @(negedge clk_i);
      chk("reset_ifq_ready", ifq_ready_o, 1'b0);
      chk("reset_exs_valid", exs_valid_o, 1'b0);
      chk("reset_hazard", hazard_o, 1'b0);
    end
    for (int cyc = 0; cyc < N_CYCLES; cyc++) begin
      @(posedge clk_i);
      #1;
      reset_i        = ($urandom_range(0, 299) == 0);
      flush_i        = ($urandom_range(0, 19) == 0);
      ifq_valid_i    = ($urandom_range(0, 9) < 7);
      ifq_ins_i      = rand_ins();
      ifq_pc_i       = {$urandom_range(0, 32'h3fffffff), 2'b00};
      exs_ready_i    = ($urandom_range(0, 9) < 7);
      csr_done_i     = ($urandom_range(0, 9) < 2);
      ldq_wb_valid_i = ($urandom_range(0, 9) < 3);
      ldq_wb_addr_i  = 5'($urandom_range(0, 7));
      @(negedge clk_i);
      if (reset_i) begin
        e_valid = 0; e_ready = 0; e_haz = 0;
      end else begin
        blocked = ((touched_regs(m_ir) & m_pend) != 0) ||
                  ((is_csr(m_ir) || m_ir[6:0] == 7'b0001111) && m_pend != 0) ||
                  (m_mode != 0);
        e_valid = m_irv && !blocked && !flush_i;
        e_ready = !flush_i && (!m_irv || (e_valid && exs_ready_i));
        e_haz   = m_irv && blocked;
      end
      chk("ifq_ready", ifq_ready_o, e_ready);
      chk("hazard", hazard_o, e_haz);
      fire = e_valid && exs_ready_i;
      if (fire) exp_q.push_back({!is_legal(m_ir), m_ir, m_pc});
      if (reset_i) begin
        m_irv = 0; m_ir = 0; m_pc = 0; m_pend = 0; m_mode = 0;
      end else begin
        if (ldq_wb_valid_i) m_pend[ldq_wb_addr_i] = 1'b0;
        if (fire && is_load(m_ir) && m_ir[11:7] != 0) m_pend[m_ir[11:7]] = 1'b1;
        if (flush_i)                           m_mode = 0;
        else if (fire && !is_legal(m_ir))      m_mode = 2;
        else if (fire && is_csr(m_ir))         m_mode = 1;
        else if (m_mode == 1 && csr_done_i)    m_mode = 0;
        if (flush_i) m_irv = 0;
        else if (ifq_valid_i && e_ready) begin
          m_irv = 1; m_ir = ifq_ins_i; m_pc = ifq_pc_i;
        end else if (fire) m_irv = 0;
      end
    end
    @(posedge clk_i);
    #1;
    exs_ready_i = 1'b0;
    ifq_valid_i = 1'b0;
    flush_i     = 1'b0;
    reset_i     = 1'b0;
    repeat (2) @(negedge clk_i);
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL missing_issues: %0d predicted issues never seen, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
